// File: rtl/interface_switch_reader_if.sv
// IO bus request signals shared by the read-side and write-side peer devices.
// The tri-state data bus stays a plain inout net on each device.
interface interface_switch_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CTRL_W = 4
) ();
  logic              BG;
  logic [ADDR_W-1:0] addr;
  logic [CTRL_W-1:0] ctrl;

  modport master (output BG, output addr, output ctrl);
  modport slave  (input  BG, input  addr, input  ctrl);
endinterface

// File: rtl/interface_switch_reader.sv
// Read-side IO peer: synchronises and debounces switches/buttons and returns
// a snapshot, change flag and control bits on the shared tri-state data bus.
module interface_switch_reader #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WE_BIT     = 0,
  parameter int unsigned SW_W       = 24,
  parameter int unsigned BTN_W      = 5,
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic                       clk,
  input  logic                       rst,
  interface_switch_reader_if.slave   bus,
  inout  wire  [DATA_W-1:0]          data,
  input  logic [SW_W-1:0]            sw,
  input  logic [BTN_W-1:0]           btn,
  output logic                       irq
);

  localparam int unsigned IN_W  = SW_W + BTN_W;
  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_CTRL = 2'b00;
  localparam logic [SEL_W-1:0] SEL_DATA = 2'b01;

  logic [IN_W-1:0]   sync1;
  logic [IN_W-1:0]   s_vec;
  logic [IN_W-1:0]   prev;
  logic [IN_W-1:0]   deb;
  logic [IN_W-1:0]   snap;
  logic [CNT_W-1:0]  cnt;
  logic              chg;
  logic              ie;
  logic              freeze;

  logic [SEL_W-1:0]  sel_c;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic              tick_c;
  logic              deb_chg_c;
  logic              drive_c;
  logic [DATA_W-1:0] rd_val_c;
  logic              unused_bus_bits;

  // Address/direction decode and debounce strobes.
  always_comb begin
    sel_c     = bus.addr[3:2];
    rd_acc_c  = bus.BG & ~bus.ctrl[WE_BIT];
    wr_acc_c  = bus.BG &  bus.ctrl[WE_BIT];
    tick_c    = (cnt == CNT_W'(DEB_CYCLES - 1));
    deb_chg_c = tick_c && (s_vec == prev) && (s_vec != deb);
  end

  assign unused_bus_bits = ^{bus.addr, bus.ctrl, data};

  // Two-flop synchroniser for the raw asynchronous inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s_vec <= '0;
    end else begin
      sync1 <= {btn, sw};
      s_vec <= sync1;
    end
  end

  // Debounce sample tick generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A level is accepted only when two consecutive ticks agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      deb  <= '0;
    end else if (tick_c) begin
      prev <= s_vec;
      if (s_vec == prev) begin
        deb <= s_vec;
      end
    end
  end

  // Snapshot follows the debounced value unless frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if (!freeze) begin
      snap <= deb;
    end
  end

  // Change flag: a new debounced value beats a concurrent DATA read clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg <= 1'b0;
    end else if (deb_chg_c) begin
      chg <= 1'b1;
    end else if (rd_acc_c && (sel_c == SEL_DATA)) begin
      chg <= 1'b0;
    end
  end

  // Control register and registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie     <= 1'b0;
      freeze <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc_c && (sel_c == SEL_CTRL)) begin
        ie     <= data[0];
        freeze <= data[1];
      end
      irq <= ie & chg;
    end
  end

  // Zero-wait-state read mux; reserved addresses read as zero.
  always_comb begin
    rd_val_c = '0;
    drive_c  = rd_acc_c & ~rst;
    case (sel_c)
      SEL_CTRL: rd_val_c = DATA_W'({freeze, ie, chg});
      SEL_DATA: rd_val_c = DATA_W'(snap);
      default:  rd_val_c = '0;
    endcase
  end

  assign data = drive_c ? rd_val_c : {DATA_W{1'bz}};

endmodule

// File: tb/tb_interface_switch_reader.sv
// Bench for interface_switch_reader: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the debounced device.
module tb_interface_switch_reader;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WE_BIT     = 0;
  localparam int unsigned SW_W       = 24;
  localparam int unsigned BTN_W      = 5;
  localparam int unsigned DEB_CYCLES = 4;
  localparam int unsigned IN_W       = SW_W + BTN_W;
  localparam logic [DATA_W-1:0] RELEASED = '1;

  logic clk = 1'b0;
  logic rst;
  logic [SW_W-1:0]  sw;
  logic [BTN_W-1:0] btn;
  logic irq;

  interface_switch_reader_if #(.ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) bus ();

  wire  [DATA_W-1:0] data;
  logic              drv_en;
  logic [DATA_W-1:0] drv_val;
  assign data = drv_en ? drv_val : {DATA_W{1'bz}};
  pullup pu (data);

  interface_switch_reader #(
    .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .WE_BIT(WE_BIT),
    .SW_W(SW_W), .BTN_W(BTN_W), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .data(data), .sw(sw), .btn(btn), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] last_bus;
  logic              last_irq;

  // Reference model state: raw-input history, tick phase, accepted level.
  logic [IN_W-1:0] m_q[$];
  int unsigned     m_cyc;
  logic [IN_W-1:0] m_last, m_acc, m_snap;
  bit              m_chg, m_ie, m_frz, m_irq, m_valid;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return (m_cyc % DEB_CYCLES) == DEB_CYCLES - 1;
  endfunction

  function automatic bit m_deb_change_now();
    return m_tick() && (m_q[0] == m_last) && (m_q[0] != m_acc);
  endfunction

  function automatic logic [DATA_W-1:0] m_expect_bus();
    logic [1:0] sel;
    sel = bus.addr[3:2];
    if (drv_en) return drv_val;
    if (rst || !bus.BG || bus.ctrl[WE_BIT]) return RELEASED;
    if (sel == 2'b00) return DATA_W'({m_frz, m_ie, m_chg});
    if (sel == 2'b01) return DATA_W'(m_snap);
    return '0;
  endfunction

  task automatic m_update();
    logic [IN_W-1:0] s, n_snap;
    logic [1:0] sel;
    bit changed, n_irq;
    if (rst) begin
      m_q.delete();
      m_q.push_back('0);
      m_q.push_back('0);
      m_cyc = 0; m_last = '0; m_acc = '0; m_snap = '0;
      m_chg = 0; m_ie = 0; m_frz = 0; m_irq = 0; m_valid = 1;
      return;
    end
    sel     = bus.addr[3:2];
    s       = m_q[0];
    changed = 0;
    n_irq   = m_ie & m_chg;
    n_snap  = m_frz ? m_snap : m_acc;
    if (m_tick()) begin
      if (s == m_last && s != m_acc) begin
        m_acc = s;
        changed = 1;
      end
      m_last = s;
    end
    if (changed) m_chg = 1;
    else if (bus.BG && !bus.ctrl[WE_BIT] && sel == 2'b01) m_chg = 0;
    if (bus.BG && bus.ctrl[WE_BIT] && sel == 2'b00) begin
      m_ie  = drv_val[0];
      m_frz = drv_val[1];
    end
    m_irq  = n_irq;
    m_snap = n_snap;
    void'(m_q.pop_front());
    m_q.push_back({btn, sw});
    m_cyc++;
  endtask

  // One clock: compare bus and irq mid-cycle, advance the model, move past the edge.
  task automatic step();
    @(negedge clk);
    last_bus = data;
    last_irq = irq;
    check_eq("bus", last_bus, m_expect_bus());
    if (m_valid) check_eq("irq", DATA_W'(last_irq), DATA_W'(m_irq));
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.BG = 1'b0; bus.ctrl = '0; bus.addr = '0; drv_en = 1'b0; drv_val = '0;
  endtask

  task automatic rd(input logic [1:0] sel);
    bus.BG = 1'b1; bus.ctrl = '0; bus.addr = $urandom; bus.addr[3:2] = sel;
    drv_en = 1'b0;
    step();
    idle();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [DATA_W-1:0] val);
    bus.BG = 1'b1; bus.ctrl = '0; bus.ctrl[WE_BIT] = 1'b1;
    bus.addr = $urandom; bus.addr[3:2] = sel;
    drv_en = 1'b1; drv_val = val;
    step();
    idle();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    idle();
    m_valid = 0;
    rst = 1'b1; sw = '1; btn = '0;
    idle_n(2);
    check_eq("rst_release", last_bus, RELEASED);
    check_eq("rst_irq", DATA_W'(last_irq), '0);
    rst = 1'b0;

    // Debounce: new level needs two agreeing ticks.
    sw = 24'h00A5A5; btn = 5'b10001;
    rd(2'b00); check_eq("rst_ctrl", last_bus, '0);
    rd(2'b01); check_eq("deb_early", last_bus, '0);
    idle_n(7);
    rd(2'b00); check_eq("deb_chg", last_bus, 32'h1);
    rd(2'b01); check_eq("deb_data", last_bus, 32'h1100A5A5);

    // Glitch between ticks is rejected.
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_cyc % DEB_CYCLES == 0) found = 1; else step();
    end
    sw[0] = ~sw[0]; step(); sw[0] = ~sw[0];
    idle_n(10);
    rd(2'b01); check_eq("glitch_data", last_bus, 32'h1100A5A5);
    rd(2'b00); check_eq("glitch_ctrl", last_bus, '0);

    // IRQ path.
    wr(2'b00, 32'h1);
    sw = 24'h00A5A4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = m_chg;
    end
    check_eq("chg_wait_timeout", DATA_W'(found), 32'h1);
    step(); step();
    check_eq("irq_set", DATA_W'(last_irq), 32'h1);
    rd(2'b01);
    step(); step();
    check_eq("irq_clear", DATA_W'(last_irq), '0);
    rd(2'b00); check_eq("ctrl_after_rd", last_bus, 32'h2);

    // Debounced change coinciding with a DATA read keeps CHG set.
    sw = 24'h00A5A5;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_deb_change_now()) begin rd(2'b01); found = 1; end
      else step();
    end
    check_eq("coincide_timeout", DATA_W'(found), 32'h1);
    rd(2'b00); check_eq("set_wins", last_bus, 32'h3);

    // Freeze holds the snapshot.
    wr(2'b00, 32'h2);
    sw = 24'h123456;
    idle_n(14);
    rd(2'b00); check_eq("frz_ctrl", last_bus, 32'h5);
    rd(2'b01); check_eq("frz_data", last_bus, 32'h1100A5A5);
    wr(2'b00, 32'h0);
    step();
    rd(2'b01); check_eq("unfrz_data", last_bus, 32'h11123456);

    // Bus hygiene.
    bus.BG = 1'b0; bus.addr = 32'h4; step();
    check_eq("bg0_release", last_bus, RELEASED);
    idle();
    wr(2'b01, 32'hDEADBEEF);
    rd(2'b00); check_eq("dwr_ctrl", last_bus, '0);
    rd(2'b01); check_eq("dwr_data", last_bus, 32'h11123456);
    rd(2'b10); check_eq("reserved", last_bus, '0);
    rst = 1'b1; rd(2'b01);
    check_eq("rst_mid_access", last_bus, RELEASED);
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 31));
      if (r == 0) {btn, sw} = IN_W'($urandom);
      else if (r == 1) sw[$urandom_range(0, SW_W - 1)] ^= 1'b1;
      else if (r == 2) btn[$urandom_range(0, BTN_W - 1)] ^= 1'b1;
      rst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: rd(2'($urandom));
        1: wr(2'($urandom), $urandom);
        2: begin
             bus.BG = 1'b0; bus.ctrl = 4'($urandom); bus.addr = $urandom;
             drv_en = bus.ctrl[WE_BIT]; drv_val = $urandom;
             step(); idle();
           end
        default: step();
      endcase
    end
    rst = 1'b0;
    idle_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
